ifid_fetch_stage: RTL and testbench

- Consumer end of the hazard-control interface.
- Owns the PC register, the instruction-memory address, and the IF/ID pipeline register.
- Applies the hold, flush and redirect requests raised by hazard detection and by branch/jump resolution in ID.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/ifid_fetch_stage_pkg.sv | 32 +++
 rtl/ifid_fetch_stage_sat_counter.sv | 26 ++
 rtl/ifid_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_ifid_fetch_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ifid_fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
package ifid_fetch_stage_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Redirect source selected when more than one request is raised.
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_JR     = 2'd3
    } redir_sel_e;

    // Priority: taken branch, then jump, then register jump.
    function automatic redir_sel_e redirect_select(input logic br, input logic jp, input logic jr);
        if (br) begin
            return REDIR_BRANCH;
        end else if (jp) begin
            return REDIR_JUMP;
        end else if (jr) begin
            return REDIR_JR;
        end
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/ifid_fetch_stage_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    // Count enabled edges until the all-ones ceiling.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ifid_fetch_stage.sv
// Fetch stage: PC register, imem address, IF/ID register and perf counters.
module ifid_fetch_stage
    import ifid_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pc_hold,
    input  logic             i_ifid_hold,
    input  logic             i_flush,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_branch_target,
    input  logic             i_jump,
    input  logic [31:0]      i_jump_target,
    input  logic             i_jr,
    input  logic [31:0]      i_jr_target,
    input  logic [31:0]      i_imem_instr,
    output logic [31:0]      o_imem_addr,
    output logic [31:0]      o_ifId_instr,
    output logic [31:0]      o_ifId_pc_plus4,
    output logic             o_ifId_valid,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc_plus4_next;
    logic        w_valid_next;
    logic        w_flush_taken;
    logic [31:0] w_seq_pc;
    logic [31:0] w_redir_target;
    redir_sel_e  w_redir_sel;

    assign w_seq_pc    = r_pc + PC_STEP;
    assign w_redir_sel = redirect_select(i_branch_taken, i_jump, i_jr);

    // Selected redirect destination.
    always_comb begin
        w_redir_target = w_seq_pc;
        case (w_redir_sel)
            REDIR_BRANCH: w_redir_target = i_branch_target;
            REDIR_JUMP:   w_redir_target = i_jump_target;
            REDIR_JR:     w_redir_target = i_jr_target;
            default:      w_redir_target = w_seq_pc;
        endcase
    end

    // Next-state and next-value logic for PC and IF/ID.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_pc_plus4_next = r_pc_plus4;
        w_valid_next    = r_valid;
        w_flush_taken   = 1'b0;
        case (r_state)
            BOOT: begin
                // First fetch only completes with both halves free to move.
                if (!i_pc_hold && !i_ifid_hold) begin
                    w_pc_next       = w_seq_pc;
                    w_instr_next    = i_imem_instr;
                    w_pc_plus4_next = w_seq_pc;
                    w_valid_next    = 1'b1;
                    w_state_next    = RUN;
                end
            end
            RUN: begin
                if (!i_pc_hold) begin
                    w_pc_next = w_redir_target;
                end
                if (!i_ifid_hold) begin
                    if (i_flush) begin
                        w_instr_next    = NOP_INSTR;
                        w_pc_plus4_next = '0;
                        w_valid_next    = 1'b0;
                        w_flush_taken   = 1'b1;
                    end else begin
                        w_instr_next    = i_imem_instr;
                        w_pc_plus4_next = w_seq_pc;
                        w_valid_next    = 1'b1;
                    end
                end
            end
            default: w_state_next = BOOT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_pc_plus4 <= w_pc_plus4_next;
            r_valid    <= w_valid_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_ifid_hold),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_flush_taken),
        .o_count (o_flush_count)
    );

    assign o_imem_addr     = r_pc;
    assign o_ifId_instr    = r_instr;
    assign o_ifId_pc_plus4 = r_pc_plus4;
    assign o_ifId_valid    = r_valid;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Self-checking bench for ifid_fetch_stage against a behavioural model.
module tb_ifid_fetch_stage;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             reset, pc_hold, ifid_hold, flush;
    logic             branch_taken, jump, jr;
    logic [31:0]      branch_target, jump_target, jr_target;
    logic [31:0]      imem_instr, imem_addr, ifId_instr, ifId_pc_plus4;
    logic             ifId_valid;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0]      m_pc, m_instr, m_pp4;
    logic             m_valid, m_boot;
    logic [CNT_W-1:0] m_stall, m_flush;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
    endfunction

    always #5 clk = ~clk;

    assign imem_instr = mem_word(imem_addr);

    ifid_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_pc_hold       (pc_hold),
        .i_ifid_hold     (ifid_hold),
        .i_flush         (flush),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_jr            (jr),
        .i_jr_target     (jr_target),
        .i_imem_instr    (imem_instr),
        .o_imem_addr     (imem_addr),
        .o_ifId_instr    (ifId_instr),
        .o_ifId_pc_plus4 (ifId_pc_plus4),
        .o_ifId_valid    (ifId_valid),
        .o_stall_cycles  (stall_cycles),
        .o_flush_count   (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".instr"}, ifId_instr, m_instr);
        check({tag, ".pp4"},   ifId_pc_plus4, m_pp4);
        check({tag, ".valid"}, {31'd0, ifId_valid}, {31'd0, m_valid});
        check({tag, ".stall"}, {16'd0, stall_cycles}, {16'd0, m_stall});
        check({tag, ".flush"}, {16'd0, flush_count}, {16'd0, m_flush});
    endtask

    // One clock: drive inputs, advance the model by the stated rules, optionally compare.
    task automatic step(input logic rst, input logic ph, input logic ih, input logic fl,
                        input logic bt, input logic [31:0] btg,
                        input logic jp, input logic [31:0] jtg,
                        input logic j_r, input logic [31:0] jrtg,
                        input bit chk, input string tag);
        logic [31:0] seq, tgt;
        reset = rst; pc_hold = ph; ifid_hold = ih; flush = fl;
        branch_taken = bt; branch_target = btg;
        jump = jp; jump_target = jtg; jr = j_r; jr_target = jrtg;
        seq = m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            m_boot = 1'b1; m_stall = '0; m_flush = '0;
        end else begin
            if (m_boot) begin
                if (!ph && !ih) begin
                    m_instr = mem_word(m_pc); m_pp4 = seq; m_valid = 1'b1;
                    m_pc = seq; m_boot = 1'b0;
                end
            end else begin
                tgt = bt ? btg : jp ? jtg : j_r ? jrtg : seq;
                if (!ih) begin
                    if (fl) begin
                        m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
                        if (m_flush != CMAX) m_flush++;
                    end else begin
                        m_instr = mem_word(m_pc); m_pp4 = seq; m_valid = 1'b1;
                    end
                end
                if (!ph) m_pc = tgt;
            end
            if (ih && m_stall != CMAX) m_stall++;
        end
        @(posedge clk);
        #1;
        if (chk) check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, tag);
    endtask

    initial begin
        m_pc = '0; m_instr = '0; m_pp4 = '0; m_valid = 1'b0; m_boot = 1'b1;
        m_stall = '0; m_flush = '0;
        @(negedge clk);

        // Reset, then free-running fetch.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "rst0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "rst1");
        check("rst.addr0", imem_addr, 32'h0);
        idle("boot");
        check("boot.pp4", ifId_pc_plus4, 32'h4);
        idle("run1");
        check("run1.pp4", ifId_pc_plus4, 32'h8);
        idle("run2");
        check("run2.pp4", ifId_pc_plus4, 32'hC);
        idle("to10");
        check("at10", imem_addr, 32'h10);

        // Full hold for three cycles at PC=0x10.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "hold");
        check("hold.stall3", {16'd0, stall_cycles}, 32'd3);
        idle("resume");
        check("resume.addr", imem_addr, 32'h14);

        // Branch with flush at PC=0x20.
        idle("to18"); idle("to1c"); idle("to20");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "brflush");
        check("brflush.addr", imem_addr, 32'h100);
        check("brflush.valid", {31'd0, ifId_valid}, 32'd0);
        idle("brtgt");
        check("brtgt.pp4", ifId_pc_plus4, 32'h104);
        check("brtgt.flush1", {16'd0, flush_count}, 32'd1);

        // All redirects together: branch wins.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, "prio");
        check("prio.addr", imem_addr, 32'h200);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, "prio_jp");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1, "prio_jr");
        // Same redirects with both holds and flush: nothing moves.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1, "prio_hold");
        check("prio_hold.addr", imem_addr, 32'h400);
        // Partial holds and a misaligned target.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "pc_only");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0123, 1'b0, 32'h0, 1'b1, "ifid_only");
        check("misaligned", imem_addr, 32'h0000_0123);

        // Randomized traffic, including occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            logic r_ph, r_ih, r_fl, r_bt, r_jp, r_jr, r_rst;
            r_rst = ($urandom_range(0, 63) == 0);
            r_ph  = ($urandom_range(0, 4) == 0);
            r_ih  = ($urandom_range(0, 4) == 0);
            r_fl  = ($urandom_range(0, 3) == 0);
            r_bt  = ($urandom_range(0, 5) == 0);
            r_jp  = ($urandom_range(0, 5) == 0);
            r_jr  = ($urandom_range(0, 5) == 0);
            step(r_rst, r_ph, r_ih, r_fl, r_bt, $urandom, r_jp, $urandom, r_jr, $urandom, 1'b1, "rand");
        end

        // Long stall to saturate the stall counter, then reset mid-stall.
        for (int i = 0; i < 65540; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "sat");
        check_all("sat");
        check("sat.max", {16'd0, stall_cycles}, 32'h0000_FFFF);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "midrst");
        check("midrst.stall0", {16'd0, stall_cycles}, 32'd0);

        // PC wrap from 0xFFFF_FFFC.
        idle("wboot");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, "wjump");
        idle("wrap");
        check("wrap.addr", imem_addr, 32'h0);
        check("wrap.pp4", ifId_pc_plus4, 32'h0);
        check("wrap.valid", {31'd0, ifId_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
